// File: rtl/instr_mem_ctrl.sv
// Byte-addressed big-endian instruction memory. It fills every word with a boot pattern after reset,
// then serves valid/ready requests with a fixed-latency response pipeline.
module instr_mem_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 12,
  parameter int                DEPTH_WORDS = 256,
  parameter int                RD_LAT      = 1,
  parameter logic [DATA_W-1:0] INIT_WORD   = 32'hE0000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WIDX_W = ADDR_W - OFF_W;
  localparam logic [WIDX_W:0]  DEPTH_L  = (WIDX_W + 1)'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
  logic [0:0]        state_r;
  logic [IDX_W-1:0]  init_ptr_r;
  logic              done_r;

  logic [RD_LAT-1:0] vld_r;
  logic [RD_LAT-1:0] err_r;
  logic [DATA_W-1:0] data_r [RD_LAT];

  logic [WIDX_W-1:0] widx_s;
  logic [IDX_W-1:0]  idx_s;
  logic              misalign_s;
  logic              oor_s;
  logic              err_s;
  logic              accept_s;
  logic              wr_s;
  logic [DATA_W-1:0] rd_word_s;

  // Lowest-address byte sits in the top lane, so lane b of the word is simply bits [8b+7:8b].
  assign widx_s     = req_addr[ADDR_W-1:OFF_W];
  assign idx_s      = widx_s[IDX_W-1:0];
  assign misalign_s = (req_addr[OFF_W-1:0] != '0);
  assign oor_s      = ({1'b0, widx_s} >= DEPTH_L);
  assign err_s      = misalign_s | oor_s;
  assign accept_s   = req_valid & done_r;
  assign wr_s       = accept_s & req_write & ~err_s;
  assign rd_word_s  = mem_r[idx_s];

  assign req_ready  = done_r;
  assign init_done  = done_r;
  assign rsp_valid  = vld_r[RD_LAT-1];
  assign rsp_err    = err_r[RD_LAT-1];
  assign rsp_data   = data_r[RD_LAT-1];

  // Init sequencer: walks every word once, then parks in RUN until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_INIT;
      init_ptr_r <= '0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_ptr_r <= init_ptr_r + IDX_W'(1);
          if (init_ptr_r == LAST_IDX) begin
            state_r <= ST_RUN;
            done_r  <= 1'b1;
          end else begin
            done_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          done_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_INIT;
          init_ptr_r <= '0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; deliberately unreset, the init sequencer owns its contents.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[init_ptr_r] <= INIT_WORD;
    end else if (wr_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_be[b]) begin
          mem_r[idx_s][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures the accepted request, the last stage drives the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= '0;
      err_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_r[i] <= '0;
      end
    end else begin
      vld_r[0]  <= accept_s;
      err_r[0]  <= accept_s & err_s;
      data_r[0] <= (accept_s && !req_write && !err_s) ? rd_word_s : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i]  <= vld_r[i-1];
        err_r[i]  <= err_r[i-1];
        data_r[i] <= data_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: drives one stimulus stream into an RD_LAT=1 and an RD_LAT=3 instance.
module tb_instr_mem_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [11:0] req_addr  = 12'h000;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be    = 4'h0;

  logic        ready1, vld1, err1, done1;
  logic [31:0] data1;
  logic        ready3, vld3, err3, done3;
  logic [31:0] data3;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  exp_t q1[$];
  exp_t q3[$];

  instr_mem_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld1), .rsp_data(data1), .rsp_err(err1), .init_done(done1)
  );

  instr_mem_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld3), .rsp_data(data3), .rsp_err(err3), .init_done(done3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; the request is accepted on the following posedge.
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    e.data = exp_d;
    e.err  = exp_e;
    e.acc  = cyc + 1;
    q1.push_back(e);
    q3.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Counts edges after reset release; also fires requests that must be ignored while INIT runs.
  task automatic init_wait();
    for (int i = 1; i <= 256; i++) begin
      req_valid = (i >= 10 && i <= 12) || (i == 255);
      req_write = (i == 11) || (i == 255);
      req_addr  = 12'h004;
      req_wdata = 32'hDEADBEEF;
      req_be    = 4'hF;
      @(posedge clk); #1;
      if (i == 1 || i == 255) begin
        chk("init_done_early_lat1", {31'b0, done1}, 32'd0);
        chk("init_done_early_lat3", {31'b0, done3}, 32'd0);
        chk("req_ready_early", {31'b0, ready1}, 32'd0);
      end else if (i == 256) begin
        chk("init_done_256_lat1", {31'b0, done1}, 32'd1);
        chk("init_done_256_lat3", {31'b0, done3}, 32'd1);
        chk("req_ready_256", {31'b0, ready1}, 32'd1);
      end
    end
    req_valid = 1'b0;
  endtask

  // Monitor for the RD_LAT=1 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && vld1) begin
        if (q1.size() == 0) begin
          chk("unexpected_rsp_lat1", {31'b0, vld1}, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("rsp_data_lat1", data1, e.data);
          chk("rsp_err_lat1", {31'b0, err1}, {31'b0, e.err});
          chk("rsp_timing_lat1", cyc, e.acc);
        end
      end
    end
  end

  // Monitor for the RD_LAT=3 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && vld3) begin
        if (q3.size() == 0) begin
          chk("unexpected_rsp_lat3", {31'b0, vld3}, 32'd0);
        end else begin
          e = q3.pop_front();
          chk("rsp_data_lat3", data3, e.data);
          chk("rsp_err_lat3", {31'b0, err3}, {31'b0, e.err});
          chk("rsp_timing_lat3", cyc, e.acc + 2);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, vld1}, 32'd0);
    chk("rst_rsp_data", data1, 32'd0);
    chk("rst_rsp_err", {31'b0, err1}, 32'd0);
    chk("rst_init_done", {31'b0, done1}, 32'd0);
    chk("rst_req_ready", {31'b0, ready3}, 32'd0);
    rst = 1'b1;
    init_wait();

    issue(1'b0, 12'h000, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b0, 12'h004, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b1, 12'h004, 32'hE3A00014, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 12'h004, 32'h0, 4'h0, 32'hE3A00014, 1'b0);
    issue(1'b1, 12'h008, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    issue(1'b0, 12'h008, 32'h0, 4'h0, 32'hE0220044, 1'b0);
    idle(2);
    issue(1'b0, 12'h006, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b1, 12'h400, 32'h55555555, 4'hF, 32'h0, 1'b1);
    issue(1'b0, 12'h000, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b1, 12'h00C, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 12'h00C, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b1, 12'h010, 32'hAABBCCDD, 4'b1000, 32'h0, 1'b0);
    issue(1'b1, 12'h014, 32'hAABBCCDD, 4'b0010, 32'h0, 1'b0);
    issue(1'b0, 12'h010, 32'h0, 4'h0, 32'hAA000000, 1'b0);
    issue(1'b0, 12'h014, 32'h0, 4'h0, 32'hE000CC00, 1'b0);
    issue(1'b0, 12'hFFC, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b0, 12'h3FC, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b0, 12'h001, 32'h0, 4'h0, 32'h0, 1'b1);
    idle(5);
    issue(1'b0, 12'h000, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b0, 12'h004, 32'h0, 4'h0, 32'hE3A00014, 1'b0);
    issue(1'b0, 12'h008, 32'h0, 4'h0, 32'hE0220044, 1'b0);
    idle(6);
    chk("queue_drained_lat1", q1.size(), 32'd0);
    chk("queue_drained_lat3", q3.size(), 32'd0);

    // Reset lands while a read is still in flight in both pipelines.
    issue(1'b1, 12'h004, 32'h12345678, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 12'h004, 32'h0, 4'h0, 32'h12345678, 1'b0);
    req_valid = 1'b0;
    chk("inflight_before_rst_lat1", {31'b0, vld1}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_rsp_valid_lat1", {31'b0, vld1}, 32'd0);
    chk("async_rst_rsp_valid_lat3", {31'b0, vld3}, 32'd0);
    chk("async_rst_rsp_data_lat1", data1, 32'd0);
    chk("async_rst_init_done", {31'b0, done1}, 32'd0);
    q1.delete();
    q3.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    init_wait();
    issue(1'b0, 12'h004, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    issue(1'b0, 12'h008, 32'h0, 4'h0, 32'hE0000000, 1'b0);
    idle(6);
    chk("final_drained_lat1", q1.size(), 32'd0);
    chk("final_drained_lat3", q3.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised, byte-addressed, big-endian instruction memory with a valid/ready request port and a fixed-latency response port.
- Supports byte-enable writes, alignment and range error reporting, and a configurable read pipeline depth.
- After reset, a sequential init engine fills every word with a boot pattern.
- Sits between the fetch stage (reads) and the program loader/debug port (writes).

Parameters:
- DATA_W, 32, word width in bits; multiple of 8; BYTES = DATA_W/8 must be a power of 2.
- ADDR_W, 12, byte-address width; must satisfy 2^ADDR_W >= DEPTH_WORDS*BYTES.
- DEPTH_WORDS, 256, number of words stored.
- RD_LAT, 1, response latency in cycles; legal range 1..4.
- INIT_WORD, 32'hE0000000, pattern written to every word during init.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, request can be accepted this cycle.
- req_write, input, 1, 1 = write, 0 = read.
- req_addr, input, ADDR_W, byte address of the word.
- req_wdata, input, DATA_W, write data.
- req_be, input, BYTES, byte enables.
- rsp_valid, output, 1, response present, one-cycle pulse per accepted request.
- rsp_data, output, DATA_W, read data; 0 for writes and errors.
- rsp_err, output, 1, the request was misaligned or out of range.
- init_done, output, 1, init complete; memory usable.

Behaviour:
- Reset (rst=0, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0.
  - Response pipeline is flushed; FSM enters INIT with init_ptr=0.
  - Memory array is not cleared asynchronously.
- FSM states:
  - INIT: each posedge writes INIT_WORD to word init_ptr, then increments init_ptr. On the posedge that writes word DEPTH_WORDS-1, move to RUN and set init_done=1 and req_ready=1 (registered). With the defaults, init_done rises on the 256th posedge after rst release.
  - RUN: req_ready=1 constantly. Stays in RUN until reset.
- Requests while in INIT are ignored: no memory effect, no response.
- Accept occurs when req_valid && req_ready at a posedge. Throughput is one request per cycle, back-to-back.
- Address decode:
  - widx = req_addr >> log2(BYTES).
  - Misaligned when req_addr[log2(BYTES)-1:0] != 0.
  - Out of range when widx >= DEPTH_WORDS.
  - Either condition is an error: no memory effect, response with rsp_err=1 and rsp_data=0.
- Byte order is big-endian:
  - The byte at the lowest address occupies bits [DATA_W-1:DATA_W-8].
  - req_be[BYTES-1] enables that byte; req_be[0] enables bits [7:0].
- Write: the enabled bytes of word widx are updated at the accept edge. The response has rsp_err=0 and rsp_data=0. be=0 is legal: no change, but a response is still produced.
- Read: the word is sampled at the accept edge. A read accepted the cycle after a write to the same word returns the new data.
- Latency: rsp_valid is asserted RD_LAT posedges after the accept edge.
  - RD_LAT=1: rsp_valid is high during the cycle following the accept.
  - Responses are in order; rsp_valid is low when nothing is due.
- No response backpressure: the consumer must take each response in the cycle it is presented.
- Reset mid-operation:
  - In-flight responses are discarded immediately.
  - init_done drops.
  - INIT reruns, overwriting all prior writes.

Test Plan:
- Release rst, hold req_valid=0 -> init_done=0 for 255 edges and 1 after the 256th edge; read 0x000 -> rsp_valid one cycle later, rsp_data=0xE0000000, rsp_err=0.
- Write 0x004 data 0xE3A00014 be=4'hF, read 0x004 on the next cycle -> write response rsp_data=0; read response 0xE3A00014.
- After init, write 0x008 data 0x11223344 be=4'b0101, then read 0x008 -> 0xE0220044.
- Read 0x006 -> rsp_err=1, rsp_data=0; write 0x400 with be=4'hF -> rsp_err=1, and a subsequent read of 0x000 is still 0xE0000000.
- RD_LAT=3 build: reads of 0x000, 0x004 and 0x008 on consecutive cycles -> rsp_valid high on 3 consecutive cycles starting 3 edges after the first accept, data in request order; requests during INIT produce no response.
- Write 0x004 = 0x12345678, assert rst mid-stream with a read in flight -> rsp_valid and init_done go 0 without a clock edge; after re-init, read 0x004 -> 0xE0000000.
